// File: rtl/riscv_pkg.sv
// Shared RV32I core types: ALU op codes, forwarding selects
// and the ID/EX pipeline register bundle.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 4;
    localparam int RW   = 5;

    localparam logic [OPW-1:0] ALU_AND = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR  = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPW-1:0] ALU_SUB = 4'b0011;
    localparam logic [OPW-1:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [OPW-1:0]  alu_op;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

endpackage

// File: rtl/forwarding_unit.sv
// Picks the freshest producer for each EX-stage source register.
// EX/MEM beats MEM/WB; x0 is never forwarded.
module forwarding_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b
);

    logic exmem_ok;
    logic memwb_ok;
    logic ex_a;
    logic ex_b;
    logic wb_a;
    logic wb_b;

    assign exmem_ok = exmem_reg_write & (exmem_rd != '0);
    assign memwb_ok = memwb_reg_write & (memwb_rd != '0);

    assign ex_a = exmem_ok & (exmem_rd == ex_rs1);
    assign ex_b = exmem_ok & (exmem_rd == ex_rs2);
    // MEM/WB hits are masked by EX/MEM hits so the selects stay one-hot
    assign wb_a = ~ex_a & memwb_ok & (memwb_rd == ex_rs1);
    assign wb_b = ~ex_b & memwb_ok & (memwb_rd == ex_rs2);

    always_comb begin
        fwd_a = FWD_NONE;
        unique case (1'b1)
            ex_a:    fwd_a = FWD_EXMEM;
            wb_a:    fwd_a = FWD_MEMWB;
            default: fwd_a = FWD_NONE;
        endcase
    end

    always_comb begin
        fwd_b = FWD_NONE;
        unique case (1'b1)
            ex_b:    fwd_b = FWD_EXMEM;
            wb_b:    fwd_b = FWD_MEMWB;
            default: fwd_b = FWD_NONE;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion
// and forwarded ALU operand selection.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_src_a_pc,
    input  logic                     id_src_b_imm,
    input  logic                     id_uses_rs2,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     ext_stall,
    input  logic                     flush,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_data,
    output logic                     hazard_stall,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_valid,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_pc
);

    id_ex_t   r;
    id_ex_t   id_pkt;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;
    logic load_in_ex;
    logic rs_match;

    // Control bits are gated so an invalid slot never writes anything
    always_comb begin
        id_pkt           = '0;
        id_pkt.valid     = id_valid;
        id_pkt.pc        = id_pc;
        id_pkt.rs1_data  = id_rs1_data;
        id_pkt.rs2_data  = id_rs2_data;
        id_pkt.imm       = id_imm;
        id_pkt.rs1       = id_rs1;
        id_pkt.rs2       = id_rs2;
        id_pkt.rd        = id_rd;
        id_pkt.alu_op    = id_alu_op;
        id_pkt.src_a_pc  = id_src_a_pc;
        id_pkt.src_b_imm = id_src_b_imm;
        id_pkt.reg_write = id_valid & id_reg_write;
        id_pkt.mem_read  = id_valid & id_mem_read;
        id_pkt.mem_write = id_valid & id_mem_write;
    end

    assign load_in_ex = r.valid & r.mem_read & (r.rd != '0);
    assign rs_match   = (r.rd == id_rs1)
                      | (id_uses_rs2 & (r.rd == id_rs2));
    assign hazard_stall = ~flush & id_valid & load_in_ex & rs_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (ext_stall) begin
            r <= r;
        end else if (hazard_stall) begin
            r <= '0;
        end else begin
            r <= id_pkt;
        end
    end

    forwarding_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd (
        .ex_rs1          (r.rs1),
        .ex_rs2          (r.rs2),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    always_comb begin
        fwd_rs1 = r.rs1_data;
        unique case (fwd_a)
            FWD_EXMEM: fwd_rs1 = exmem_result;
            FWD_MEMWB: fwd_rs1 = memwb_data;
            default:   fwd_rs1 = r.rs1_data;
        endcase
    end

    always_comb begin
        fwd_rs2 = r.rs2_data;
        unique case (fwd_b)
            FWD_EXMEM: fwd_rs2 = exmem_result;
            FWD_MEMWB: fwd_rs2 = memwb_data;
            default:   fwd_rs2 = r.rs2_data;
        endcase
    end

    assign SrcA          = r.src_a_pc  ? r.pc  : fwd_rs1;
    assign SrcB          = r.src_b_imm ? r.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign Operation     = r.alu_op;
    assign ex_valid      = r.valid;
    assign ex_rd         = r.rd;
    assign ex_reg_write  = r.reg_write;
    assign ex_mem_read   = r.mem_read;
    assign ex_mem_write  = r.mem_write;
    assign ex_pc         = r.pc;

endmodule
